vec_decode_issue: RTL and testbench

Registered, parametrised decode-and-issue stage for the CGRA RISC-V vector front end. It sits between the instruction fetch stream and the CGRA datapath. Each accepted 32-bit instruction is decoded into scalar and vector control fields, held in an output register behind a valid/ready handshake, and blocked at issue while a vector read-after-write or write-after-write hazard is outstanding. A vector-register scoreboard tracks outstanding writebacks. The `vsetivli`-configured VLEN is applied only after the pipe drains.

---
 rtl/vec_decode_issue.sv | 250 +++++++++++++++++++++++++
 tb/tb_vec_decode_issue.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_decode_issue.sv
// Decode-and-issue stage: decodes each fetched instruction, holds the bundle behind
// valid/ready, and blocks issue on vector RAW/WAW hazards tracked by a scoreboard.
module vec_decode_issue #(
  parameter int         DWIDTH_INST  = 32,
  parameter int         DWIDTH_INT   = 32,
  parameter int         DWIDTH_RFADD = 12,
  parameter int         NUM_VREG     = 32,
  parameter logic [2:0] VLEN_RST     = 3'd0,
  parameter int         CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DWIDTH_INST-1:0]  instr_tdata,
  input  logic                    instr_tvalid,
  output logic                    instr_tready,
  output logic                    dec_valid,
  input  logic                    dec_ready,
  output logic [2:0]              op,
  output logic [2:0]              op_scalar,
  output logic                    is_vle32,
  output logic                    is_vse32,
  output logic                    is_vmacc,
  output logic                    is_vmv,
  output logic                    is_beq,
  output logic                    is_csr,
  output logic                    wen_rf_scalar,
  output logic                    wen_itr,
  output logic [4:0]              rs1,
  output logic [4:0]              rs2,
  output logic [4:0]              rd,
  output logic [DWIDTH_INT-1:0]   r_immediate,
  output logic [11:0]             branch_immediate,
  output logic [DWIDTH_RFADD-1:0] itr,
  output logic [DWIDTH_RFADD-1:0] vr_addr,
  output logic [DWIDTH_RFADD-1:0] vw_addr,
  output logic [2:0]              vlen,
  input  logic                    wb_valid,
  input  logic [4:0]              wb_vreg,
  output logic [NUM_VREG-1:0]     busy_vec,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam logic [6:0]  OPC_VEC    = 7'h57;
  localparam logic [6:0]  OPC_VLE    = 7'h07;
  localparam logic [6:0]  OPC_VSE    = 7'h27;
  localparam logic [6:0]  OPC_BRANCH = 7'h63;
  localparam logic [6:0]  OPC_OPIMM  = 7'h13;
  localparam logic [6:0]  OPC_LUI    = 7'h37;
  localparam logic [6:0]  OPC_CSR    = 7'h03;
  localparam logic [11:0] CSR_SEL    = 12'hC00;

  typedef struct packed {
    logic [2:0]              op;
    logic [2:0]              op_scalar;
    logic                    is_vle32;
    logic                    is_vse32;
    logic                    is_vmacc;
    logic                    is_vmv;
    logic                    is_beq;
    logic                    is_csr;
    logic                    wen_rf_scalar;
    logic                    wen_itr;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [4:0]              rd;
    logic [DWIDTH_INT-1:0]   r_immediate;
    logic [11:0]             branch_immediate;
    logic [DWIDTH_RFADD-1:0] itr;
    logic [DWIDTH_RFADD-1:0] vr_addr;
    logic [DWIDTH_RFADD-1:0] vw_addr;
  } bundle_t;

  function automatic bundle_t reset_bundle();
    bundle_t b;
    b           = '0;
    b.op        = 3'b100;
    b.op_scalar = 3'b011;
    return b;
  endfunction

  // Keep the low min(V+1,5) bits of the register number, left-aligned below bit W-1-V.
  function automatic logic [DWIDTH_RFADD-1:0] vreg_to_addr(input logic [4:0] r,
                                                           input logic [2:0] v);
    logic [4:0]              mask;
    logic [DWIDTH_RFADD-1:0] base;
    case (v)
      3'd0:    mask = 5'h01;
      3'd1:    mask = 5'h03;
      3'd2:    mask = 5'h07;
      3'd3:    mask = 5'h0F;
      default: mask = 5'h1F;
    endcase
    base = DWIDTH_RFADD'(r & mask);
    return base << (DWIDTH_RFADD - 1 - int'(v));
  endfunction

  bundle_t               bundle_q, bundle_d, dec_s;
  logic                  dec_valid_q, dec_valid_d;
  logic [2:0]            vlen_q, vlen_d;
  logic [NUM_VREG-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]      stall_q, stall_d;

  logic [6:0]            opcode_s;
  logic [2:0]            funct3_s;
  logic [4:0]            vs2_s, vd_s;
  logic                  vmacc_s, vmv_s, vset_s, vle_s, vse_s, beq_s, addi_s, lui_s, csr_s;
  logic                  reader_s, writer_s, hazard_s, tready_s, accept_s;
  logic [NUM_VREG-1:0]   clr_vec_s, set_vec_s, busy_eff_s;
  logic [31:0]           busy_ext_s;

  assign opcode_s = instr_tdata[6:0];
  assign funct3_s = instr_tdata[14:12];
  assign vs2_s    = instr_tdata[24:20];
  assign vd_s     = instr_tdata[11:7];

  assign vmacc_s = (opcode_s == OPC_VEC) && (funct3_s == 3'd0);
  assign vmv_s   = (opcode_s == OPC_VEC) && (funct3_s == 3'd5);
  assign vset_s  = (opcode_s == OPC_VEC) && (funct3_s == 3'd7);
  assign vle_s   = (opcode_s == OPC_VLE);
  assign vse_s   = (opcode_s == OPC_VSE);
  assign beq_s   = (opcode_s == OPC_BRANCH) && (funct3_s == 3'd0);
  assign addi_s  = (opcode_s == OPC_OPIMM) && (funct3_s == 3'd0);
  assign lui_s   = (opcode_s == OPC_LUI);
  assign csr_s   = (opcode_s == OPC_CSR) && (instr_tdata[31:20] == CSR_SEL);

  assign reader_s = vmacc_s || vse_s;
  assign writer_s = vle_s || vmacc_s || vmv_s;

  // A retiring writeback releases its register in the same cycle (bypass).
  assign clr_vec_s  = wb_valid ? NUM_VREG'(32'd1 << wb_vreg) : '0;
  assign busy_eff_s = busy_q & ~clr_vec_s;
  assign busy_ext_s = 32'(busy_eff_s);

  assign hazard_s = instr_tvalid &&
                    ((reader_s && busy_ext_s[vs2_s]) ||
                     (writer_s && busy_ext_s[vd_s])  ||
                     (vset_s && (|busy_eff_s)));

  assign tready_s  = !rst && !hazard_s && (!dec_valid_q || dec_ready);
  assign accept_s  = instr_tvalid && tready_s;
  assign set_vec_s = (accept_s && writer_s) ? NUM_VREG'(32'd1 << vd_s) : '0;

  // Combinational decode of the presented instruction into an issue bundle.
  always_comb begin
    dec_s                  = reset_bundle();
    dec_s.is_vle32         = vle_s;
    dec_s.is_vse32         = vse_s;
    dec_s.is_vmacc         = vmacc_s;
    dec_s.is_vmv           = vmv_s;
    dec_s.is_beq           = beq_s;
    dec_s.is_csr           = csr_s;
    dec_s.wen_rf_scalar    = addi_s || lui_s || csr_s;
    dec_s.wen_itr          = vset_s;
    dec_s.rs1              = instr_tdata[19:15];
    dec_s.rs2              = vs2_s;
    dec_s.rd               = vd_s;
    dec_s.branch_immediate = {instr_tdata[31], instr_tdata[7], instr_tdata[30:25], instr_tdata[11:8]};
    dec_s.itr              = DWIDTH_RFADD'(instr_tdata[29:18]);
    dec_s.vr_addr          = vreg_to_addr(vs2_s, vlen_q);
    dec_s.vw_addr          = vreg_to_addr(vd_s, vlen_q);
    if (vmacc_s) begin
      dec_s.op = 3'b011;
    end else begin
      dec_s.op = 3'b100;
    end
    if (lui_s) begin
      dec_s.op_scalar = 3'b000;
    end else if (addi_s) begin
      dec_s.op_scalar = 3'b001;
    end else if (beq_s) begin
      dec_s.op_scalar = 3'b010;
    end else begin
      dec_s.op_scalar = 3'b011;
    end
    if (addi_s) begin
      dec_s.r_immediate = DWIDTH_INT'($signed(instr_tdata[31:20]));
    end else begin
      dec_s.r_immediate = DWIDTH_INT'($signed({instr_tdata[31:12], 12'h000}));
    end
  end

  // Next-state for the output register, VLEN, scoreboard and stall counter.
  always_comb begin
    bundle_d    = bundle_q;
    dec_valid_d = dec_valid_q;
    vlen_d      = vlen_q;
    stall_d     = stall_q;
    busy_d      = (busy_q & ~clr_vec_s) | set_vec_s;
    if (accept_s) begin
      bundle_d    = dec_s;
      dec_valid_d = 1'b1;
    end else if (dec_ready) begin
      dec_valid_d = 1'b0;
    end else begin
      dec_valid_d = dec_valid_q;
    end
    if (accept_s && vset_s) begin
      vlen_d = instr_tdata[17:15];
    end else begin
      vlen_d = vlen_q;
    end
    if (instr_tvalid && hazard_s && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_q    <= reset_bundle();
      dec_valid_q <= 1'b0;
      vlen_q      <= VLEN_RST;
      busy_q      <= '0;
      stall_q     <= '0;
    end else begin
      bundle_q    <= bundle_d;
      dec_valid_q <= dec_valid_d;
      vlen_q      <= vlen_d;
      busy_q      <= busy_d;
      stall_q     <= stall_d;
    end
  end

  assign instr_tready     = tready_s;
  assign dec_valid        = dec_valid_q;
  assign op               = bundle_q.op;
  assign op_scalar        = bundle_q.op_scalar;
  assign is_vle32         = bundle_q.is_vle32;
  assign is_vse32         = bundle_q.is_vse32;
  assign is_vmacc         = bundle_q.is_vmacc;
  assign is_vmv           = bundle_q.is_vmv;
  assign is_beq           = bundle_q.is_beq;
  assign is_csr           = bundle_q.is_csr;
  assign wen_rf_scalar    = bundle_q.wen_rf_scalar;
  assign wen_itr          = bundle_q.wen_itr;
  assign rs1              = bundle_q.rs1;
  assign rs2              = bundle_q.rs2;
  assign rd               = bundle_q.rd;
  assign r_immediate      = bundle_q.r_immediate;
  assign branch_immediate = bundle_q.branch_immediate;
  assign itr              = bundle_q.itr;
  assign vr_addr          = bundle_q.vr_addr;
  assign vw_addr          = bundle_q.vw_addr;
  assign vlen             = vlen_q;
  assign busy_vec         = busy_q;
  assign stall_cnt        = stall_q;

endmodule

// File: tb/tb_vec_decode_issue.sv
// Scoreboard bench for vec_decode_issue: directed instructions with hand-computed bundles.
module tb_vec_decode_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_tdata;
  logic        instr_tvalid, instr_tready;
  logic        dec_valid, dec_ready;
  logic [2:0]  op, op_scalar;
  logic        is_vle32, is_vse32, is_vmacc, is_vmv, is_beq, is_csr, wen_rf_scalar, wen_itr;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] r_immediate;
  logic [11:0] branch_immediate, itr, vr_addr, vw_addr;
  logic [2:0]  vlen;
  logic        wb_valid;
  logic [4:0]  wb_vreg;
  logic [31:0] busy_vec;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  vec_decode_issue dut (
    .clk(clk), .rst(rst),
    .instr_tdata(instr_tdata), .instr_tvalid(instr_tvalid), .instr_tready(instr_tready),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .op(op), .op_scalar(op_scalar),
    .is_vle32(is_vle32), .is_vse32(is_vse32), .is_vmacc(is_vmacc), .is_vmv(is_vmv),
    .is_beq(is_beq), .is_csr(is_csr), .wen_rf_scalar(wen_rf_scalar), .wen_itr(wen_itr),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .r_immediate(r_immediate), .branch_immediate(branch_immediate), .itr(itr),
    .vr_addr(vr_addr), .vw_addr(vw_addr), .vlen(vlen),
    .wb_valid(wb_valid), .wb_vreg(wb_vreg),
    .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  // flags = {vle32, vse32, vmacc, vmv, beq, csr, wen_rf_scalar, wen_itr}
  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  ops;
    logic [7:0]  flags;
    logic [31:0] rimm;
    logic [11:0] brimm;
    logic [11:0] itr;
    logic [11:0] vra;
    logic [11:0] vwa;
    logic [2:0]  vlen;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_act, mon_exp;
  int   n_tests = 0;
  int   n_fail  = 0;
  time  t0;

  function automatic exp_t mk(input logic [2:0] o, input logic [2:0] os, input logic [7:0] fl,
                              input logic [31:0] ri, input logic [11:0] bi, input logic [11:0] it,
                              input logic [11:0] ra, input logic [11:0] wa, input logic [2:0] vl);
    exp_t e;
    e.op = o; e.ops = os; e.flags = fl; e.rimm = ri; e.brimm = bi;
    e.itr = it; e.vra = ra; e.vwa = wa; e.vlen = vl;
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: compare every bundle the consumer takes against the next expectation.
  always @(negedge clk) begin
    if (!rst && dec_valid && dec_ready) begin
      mon_act.op    = op;
      mon_act.ops   = op_scalar;
      mon_act.flags = {is_vle32, is_vse32, is_vmacc, is_vmv, is_beq, is_csr, wen_rf_scalar, wen_itr};
      mon_act.rimm  = r_immediate;
      mon_act.brimm = branch_immediate;
      mon_act.itr   = itr;
      mon_act.vra   = vr_addr;
      mon_act.vwa   = vw_addr;
      mon_act.vlen  = vlen;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL bundle: unexpected bundle %h, required none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        check("bundle", mon_act, mon_exp);
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input exp_t e);
    bit done;
    done = 1'b0;
    exp_q.push_back(e);
    instr_tdata  = ins;
    instr_tvalid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (instr_tready) done = 1'b1;
      @(posedge clk); #1;
    end
    instr_tvalid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: instr %h not accepted, required acceptance within 50 cycles", ins);
      void'(exp_q.pop_back());
    end
  endtask

  task automatic retire(input logic [4:0] r);
    wb_valid = 1'b1;
    wb_vreg  = r;
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  localparam logic [31:0] V_LE3  = 32'h00006187;
  localparam logic [31:0] V_SET2 = 32'h01017057;
  localparam logic [31:0] V_LE5  = 32'h00006287;
  localparam logic [31:0] V_LE4  = 32'h00006207;
  localparam logic [31:0] V_MACC = 32'h00400357;
  localparam logic [31:0] V_LE0  = 32'h00006007;
  localparam logic [31:0] V_SET5 = 32'h0002F057;
  localparam logic [31:0] V_ADDI = 32'hFFF10093;
  localparam logic [31:0] V_LUI  = 32'h123452B7;
  localparam logic [31:0] V_LE7  = 32'h00006387;
  localparam logic [31:0] V_VSE  = 32'h00206027;
  localparam logic [31:0] V_BEQ  = 32'h00208463;
  localparam logic [31:0] V_CSR  = 32'hC0000183;
  localparam logic [31:0] V_VMV  = 32'h000054D7;
  localparam logic [31:0] V_NOP  = 32'h00109093;

  initial begin
    rst = 1'b1; instr_tdata = V_LE3; instr_tvalid = 1'b1; dec_ready = 1'b1;
    wb_valid = 1'b0; wb_vreg = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tready", instr_tready, 1'b0);
    check("rst_dec_valid", dec_valid, 1'b0);
    check("rst_op", {op, op_scalar}, {3'b100, 3'b011});
    check("rst_flags", {is_vle32, is_vse32, is_vmacc, is_vmv, is_beq, is_csr, wen_rf_scalar, wen_itr}, 8'h00);
    check("rst_state", {busy_vec, stall_cnt, vlen, vw_addr, r_immediate}, {32'h0, 16'h0, 3'd0, 12'h0, 32'h0});
    @(posedge clk); #1;
    rst = 1'b0; instr_tvalid = 1'b0;

    // vle32 vd=3 at vlen 0
    issue(V_LE3, mk(3'b100, 3'b011, 8'h80, 32'h00006000, 12'h401, 12'h000, 12'h000, 12'h800, 3'd0));
    @(negedge clk);
    check("vle_latency", {dec_valid, is_vle32}, 2'b11);
    check("busy_after_vle3", busy_vec, 32'h8);
    @(posedge clk); #1;
    retire(5'd3);
    @(negedge clk);
    check("busy_after_wb3", busy_vec, 32'h0);
    @(posedge clk); #1;

    // vsetivli vlen=2 with empty scoreboard, then vle32 vd=5
    issue(V_SET2, mk(3'b100, 3'b011, 8'h01, 32'h01017000, 12'h000, 12'h040, 12'h000, 12'h000, 3'd2));
    @(negedge clk);
    check("vlen_after_vset", vlen, 3'd2);
    @(posedge clk); #1;
    issue(V_LE5, mk(3'b100, 3'b011, 8'h80, 32'h00006000, 12'h402, 12'h000, 12'h000, 12'hA00, 3'd2));
    retire(5'd5);

    // RAW stall: vmacc vs2=4 behind vle32 vd=4, released by bypass
    issue(V_LE4, mk(3'b100, 3'b011, 8'h80, 32'h00006000, 12'h002, 12'h000, 12'h000, 12'h800, 3'd2));
    exp_q.push_back(mk(3'b011, 3'b011, 8'h20, 32'h00400000, 12'h003, 12'h010, 12'h800, 12'hC00, 3'd2));
    instr_tdata = V_MACC; instr_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("raw_stall_tready", instr_tready, 1'b0);
      check("raw_stall_cnt", stall_cnt, 16'(i));
      @(posedge clk); #1;
    end
    wb_valid = 1'b1; wb_vreg = 5'd4;
    @(negedge clk);
    check("bypass_tready", instr_tready, 1'b1);
    @(posedge clk); #1;
    instr_tvalid = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    check("stall_cnt_after_raw", stall_cnt, 16'd3);
    check("busy_after_vmacc", busy_vec, 32'h40);
    @(posedge clk); #1;
    retire(5'd6);

    // vsetivli waits for the scoreboard to drain
    issue(V_LE0, mk(3'b100, 3'b011, 8'h80, 32'h00006000, 12'h000, 12'h000, 12'h000, 12'h000, 3'd2));
    exp_q.push_back(mk(3'b100, 3'b011, 8'h01, 32'h0002F000, 12'h000, 12'h000, 12'h000, 12'h000, 3'd5));
    instr_tdata = V_SET5; instr_tvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("vset_stall_tready", instr_tready, 1'b0);
      check("vset_stall_vlen", vlen, 3'd2);
      @(posedge clk); #1;
    end
    wb_valid = 1'b1; wb_vreg = 5'd0;
    @(negedge clk);
    check("vset_release_tready", instr_tready, 1'b1);
    @(posedge clk); #1;
    instr_tvalid = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    check("vlen_after_vset5", vlen, 3'd5);
    check("stall_cnt_after_vset", stall_cnt, 16'd5);
    @(posedge clk); #1;

    // back-pressure on an addi with imm = 0xFFF
    dec_ready = 1'b0;
    issue(V_ADDI, mk(3'b100, 3'b001, 8'h02, 32'hFFFFFFFF, 12'hFF0, 12'hFFC, 12'h7C0, 12'h040, 3'd5));
    exp_q.push_back(mk(3'b100, 3'b000, 8'h02, 32'h12345000, 12'h492, 12'h48D, 12'h0C0, 12'h140, 3'd5));
    instr_tdata = V_LUI; instr_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_tready", instr_tready, 1'b0);
      check("bp_hold", {dec_valid, wen_rf_scalar, op_scalar, r_immediate, vr_addr},
            {1'b1, 1'b1, 3'b001, 32'hFFFFFFFF, 12'h7C0});
      @(posedge clk); #1;
    end
    dec_ready = 1'b1;
    @(negedge clk);
    check("bp_release_tready", instr_tready, 1'b1);
    @(posedge clk); #1;
    instr_tvalid = 1'b0;

    // WAW on vd=7 resolved by a same-cycle retire; the new set must win
    issue(V_LE7, mk(3'b100, 3'b011, 8'h80, 32'h00006000, 12'h403, 12'h000, 12'h000, 12'h1C0, 3'd5));
    exp_q.push_back(mk(3'b100, 3'b011, 8'h80, 32'h00006000, 12'h403, 12'h000, 12'h000, 12'h1C0, 3'd5));
    instr_tdata = V_LE7; instr_tvalid = 1'b1; wb_valid = 1'b1; wb_vreg = 5'd7;
    @(negedge clk);
    check("waw_bypass_tready", instr_tready, 1'b1);
    @(posedge clk); #1;
    instr_tvalid = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    check("set_wins_busy", busy_vec, 32'h80);
    @(posedge clk); #1;

    // decode coverage, back to back
    t0 = $time;
    issue(V_VSE, mk(3'b100, 3'b011, 8'h40, 32'h00206000, 12'h000, 12'h008, 12'h080, 12'h000, 3'd5));
    issue(V_BEQ, mk(3'b100, 3'b010, 8'h08, 32'h00208000, 12'h004, 12'h008, 12'h080, 12'h200, 3'd5));
    issue(V_CSR, mk(3'b100, 3'b011, 8'h06, 32'hC0000000, 12'hE01, 12'h000, 12'h000, 12'h0C0, 3'd5));
    issue(V_VMV, mk(3'b100, 3'b011, 8'h10, 32'h00005000, 12'h404, 12'h000, 12'h000, 12'h240, 3'd5));
    issue(V_NOP, mk(3'b100, 3'b011, 8'h00, 32'h00109000, 12'h400, 12'h004, 12'h040, 12'h040, 3'd5));
    check("throughput", 128'($time - t0), 128'd50);
    @(negedge clk);
    check("busy_after_coverage", busy_vec, 32'h280);
    @(posedge clk); #1;
    retire(5'd3);
    @(negedge clk);
    check("clear_not_busy_ignored", busy_vec, 32'h280);
    @(posedge clk); #1;
    retire(5'd7);
    retire(5'd9);
    @(negedge clk);
    check("busy_drained", busy_vec, 32'h0);
    @(posedge clk); #1;

    // reset mid-operation drops a held bundle and clears the scoreboard
    dec_ready = 1'b0;
    instr_tdata = V_LE3; instr_tvalid = 1'b1;
    @(negedge clk);
    check("pre_reset_tready", instr_tready, 1'b1);
    @(posedge clk); #1;
    instr_tvalid = 1'b0;
    @(negedge clk);
    check("pre_reset_state", {dec_valid, busy_vec}, {1'b1, 32'h8});
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_reset_state", {dec_valid, busy_vec, stall_cnt, vlen}, {1'b0, 32'h0, 16'h0, 3'd0});
    @(posedge clk); #1;
    dec_ready = 1'b1;

    repeat (3) @(posedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
